bus_burst_memory_slave: RTL and testbench
=========================================

// Module: bus_burst_memory_slave
// PURPOSE
//   Word-addressed burst memory slave on the shared bus, downstream of the ramDmaCi DMA master.
//   Serves DMA read bursts (bus->CI memory) and absorbs DMA write bursts (CI memory->bus).
//   Replaces hand-driven bus stimulus in DMA benches and is reusable as on-chip scratch memory.
//   Programmable read latency and periodic busy injection exercise master stall handling.
// PARAMETERS
//   BASE_ADDR       32'h0000_0000  byte address of word 0; window = BASE_ADDR .. BASE_ADDR+4*2^MEM_WORDS_LOG2-1
//   MEM_WORDS_LOG2  10             log2 of memory depth in 32-bit words
//   READ_LATENCY    2              idle cycles between accepted read request and first data beat (>=1)
//   BUSY_PERIOD     0              0 = never busy; N>0 = busy for 1 cycle after every N accepted write words
// PORTS
//   clock                   in   1   system clock, all logic on rising edge
//   reset                   in   1   synchronous, active-low reset (0 = reset)
//   busIn_begin_transaction in   1   1-cycle request strobe from master
//   busIn_address_data      in   32  start byte address while begin=1; write data while data_valid=1
//   busIn_read_n_write      in   1   sampled with begin: 1 = read burst, 0 = write burst
//   busIn_burst_size        in   8   sampled with begin: beats-1 (0..255)
//   busIn_data_valid        in   1   write beat valid
//   busIn_end_transaction   in   1   master ends write burst / aborts read burst
//   busOut_address_data     out  32  read data; 0 whenever busOut_data_valid=0
//   busOut_data_valid       out  1   read beat valid
//   busOut_end_transaction  out  1   1-cycle pulse after last read beat
//   busOut_busy             out  1   write stall: beat presented while busy=1 is NOT accepted
//   busOut_error            out  1   1-cycle error pulse; slave returns to IDLE
// BEHAVIOUR
//   - All outputs registered; reset=0 -> state IDLE, all outputs 0, counters 0. Memory array NOT cleared.
//   - Reset mid-burst: IDLE next cycle, outputs 0, written words kept.
//   - States: IDLE, RD_WAIT, RD_DATA, RD_END, WR_DATA, ERR.
//   - IDLE: on begin=1 latch addr, rnw, burst_size. idx=(addr-BASE_ADDR)>>2, computed 33-bit.
//     Legal iff addr[1:0]==0, addr>=BASE_ADDR, idx+burst_size < 2^MEM_WORDS_LOG2.
//     Illegal -> ERR: busOut_error=1 for 1 cycle, then IDLE, no memory access.
//   - begin while not IDLE is ignored.
//   - Read: RD_WAIT holds READ_LATENCY cycles after the begin cycle.
//     RD_DATA drives data_valid=1 for burst_size+1 consecutive cycles, beat k = mem[idx+k].
//     RD_END: end_transaction=1 for exactly 1 cycle, data_valid=0, then IDLE.
//   - busIn_end_transaction in RD_WAIT/RD_DATA aborts: IDLE next cycle, no busOut_end_transaction.
//   - Write (WR_DATA): beat accepted iff data_valid=1 && busy=0; mem[idx+k] <= data, k++.
//   - BUSY_PERIOD=N>0: after every Nth accepted word, busy=1 for the following cycle only.
//   - Accepted word number burst_size+2 (overrun) is not written -> ERR pulse -> IDLE.
//   - busIn_end_transaction in WR_DATA -> IDLE next cycle.
//     A valid non-busy beat in the same cycle is written first. Early end (fewer beats) is legal, no error.
//   - Index arithmetic modulo 2^MEM_WORDS_LOG2; legality check guarantees no wrap inside a legal burst.
// TESTING
//   1. BASE=0, mem[3..12]=100..109; read addr=12, burst=9, LAT=2 -> first valid 3 cycles after begin,
//      10 beats 100..109, then end pulse 1 cycle.
//   2. Write addr=12, burst=7, data 1..8, BUSY_PERIOD=3 -> busy after beats 3 and 6, held beat re-accepted;
//      mem[3..10]=1..8, mem[11] unchanged.
//   3. Read addr=0xFFC (idx 1023), burst=1 with depth 1024 -> error pulse 1 cycle after begin,
//      no data_valid. Repeat with addr=0x0E (unaligned) -> same.
//   4. Write burst=3 with 5 valid beats -> words 0..3 written, 5th beat: error pulse, mem[idx+4] unchanged.
//   5. Read burst=20 aborted by busIn_end_transaction after 4 beats -> data_valid=0 next cycle,
//      no end pulse, next begin served normally.
//   6. reset=0 during write after 2 beats -> outputs 0 next cycle, mem[idx],mem[idx+1] retain data;
//      begin during an active burst ignored.

Source files
------------

// File: rtl/bus_burst_memory_slave.sv
// Word-addressed burst memory slave for the shared bus.
// Serves read bursts after a programmable latency and absorbs write bursts.
// Write bursts can be throttled with a periodic one-cycle busy.
module bus_burst_memory_slave #(
  parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
  parameter int unsigned MEM_WORDS_LOG2 = 10,
  parameter int unsigned READ_LATENCY   = 2,
  parameter int unsigned BUSY_PERIOD    = 0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        busIn_begin_transaction,
  input  logic [31:0] busIn_address_data,
  input  logic        busIn_read_n_write,
  input  logic [7:0]  busIn_burst_size,
  input  logic        busIn_data_valid,
  input  logic        busIn_end_transaction,
  output logic [31:0] busOut_address_data,
  output logic        busOut_data_valid,
  output logic        busOut_end_transaction,
  output logic        busOut_busy,
  output logic        busOut_error
);

  localparam int unsigned Depth = 2 ** MEM_WORDS_LOG2;
  localparam int unsigned Aw    = MEM_WORDS_LOG2;

  // Wait counter preload: RD_WAIT lasts READ_LATENCY cycles after the begin cycle.
  localparam logic [15:0] WaitInit = 16'(READ_LATENCY - 1);

  localparam bit          BusyEn      = (BUSY_PERIOD != 0);
  localparam int unsigned BusyLastInt = (BUSY_PERIOD == 0) ? 0 : BUSY_PERIOD - 1;
  localparam logic [15:0] BusyLast    = 16'(BusyLastInt);

  typedef enum logic [2:0] {
    StIdle,
    StRdWait,
    StRdData,
    StRdEnd,
    StWrData,
    StErr
  } state_e;

  state_e        state_q;
  logic [31:0]   mem [Depth];
  logic [Aw-1:0] ptr_q;
  logic [7:0]    burst_q;
  logic [7:0]    beats_q;     // read beats still to issue after the current one
  logic [8:0]    wr_cnt_q;    // accepted write words in this burst
  logic [15:0]   wait_q;
  logic [15:0]   busy_cnt_q;  // accepted words modulo BUSY_PERIOD

  logic [32:0] diff;
  logic [32:0] idx_wide;
  logic [32:0] last_idx;
  logic        legal;
  logic        wr_accept;
  logic        wr_overrun;
  logic        wr_en;

  // Request legality, done 33 bits wide so an address below BASE_ADDR shows up as a borrow.
  always_comb begin
    diff     = {1'b0, busIn_address_data} - {1'b0, BASE_ADDR};
    idx_wide = diff >> 2;
    last_idx = idx_wide + 33'(busIn_burst_size);
    legal    = (busIn_address_data[1:0] == 2'b00) && !diff[32] && (last_idx < 33'(Depth));
  end

  // Write beat handshake; the word after the last legal one is refused.
  always_comb begin
    wr_accept  = (state_q == StWrData) && busIn_data_valid && !busOut_busy;
    wr_overrun = (wr_cnt_q == ({1'b0, burst_q} + 9'd1));
    wr_en      = reset && wr_accept && !wr_overrun;
  end

  // Memory array, deliberately untouched by reset.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem[ptr_q] <= busIn_address_data;
    end
  end

  // Control FSM with registered bus outputs.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q                <= StIdle;
      ptr_q                  <= '0;
      burst_q                <= '0;
      beats_q                <= '0;
      wr_cnt_q               <= '0;
      wait_q                 <= '0;
      busy_cnt_q             <= '0;
      busOut_address_data    <= '0;
      busOut_data_valid      <= 1'b0;
      busOut_end_transaction <= 1'b0;
      busOut_busy            <= 1'b0;
      busOut_error           <= 1'b0;
    end else begin
      busOut_address_data    <= '0;
      busOut_data_valid      <= 1'b0;
      busOut_end_transaction <= 1'b0;
      busOut_busy            <= 1'b0;
      busOut_error           <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (busIn_begin_transaction) begin
            burst_q    <= busIn_burst_size;
            beats_q    <= busIn_burst_size;
            ptr_q      <= idx_wide[Aw-1:0];
            wr_cnt_q   <= '0;
            busy_cnt_q <= '0;
            wait_q     <= WaitInit;
            if (!legal) begin
              state_q      <= StErr;
              busOut_error <= 1'b1;
            end else if (busIn_read_n_write) begin
              state_q <= StRdWait;
            end else begin
              state_q <= StWrData;
            end
          end
        end
        StRdWait: begin
          if (busIn_end_transaction) begin
            state_q <= StIdle;
          end else if (wait_q == '0) begin
            state_q             <= StRdData;
            busOut_data_valid   <= 1'b1;
            busOut_address_data <= mem[ptr_q];
            ptr_q               <= ptr_q + 1'b1;
          end else begin
            wait_q <= wait_q - 16'd1;
          end
        end
        StRdData: begin
          if (busIn_end_transaction) begin
            state_q <= StIdle;
          end else if (beats_q == '0) begin
            state_q                <= StRdEnd;
            busOut_end_transaction <= 1'b1;
          end else begin
            busOut_data_valid   <= 1'b1;
            busOut_address_data <= mem[ptr_q];
            ptr_q               <= ptr_q + 1'b1;
            beats_q             <= beats_q - 8'd1;
          end
        end
        StRdEnd: state_q <= StIdle;
        StWrData: begin
          if (wr_accept && wr_overrun) begin
            state_q      <= StErr;
            busOut_error <= 1'b1;
          end else begin
            if (wr_accept) begin
              ptr_q      <= ptr_q + 1'b1;
              wr_cnt_q   <= wr_cnt_q + 9'd1;
              busy_cnt_q <= (busy_cnt_q == BusyLast) ? 16'd0 : busy_cnt_q + 16'd1;
              busOut_busy <= BusyEn && (busy_cnt_q == BusyLast) && !busIn_end_transaction;
            end
            if (busIn_end_transaction) begin
              state_q <= StIdle;
            end
          end
        end
        StErr:   state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_burst_memory_slave.sv
// Directed bench for bus_burst_memory_slave: reads, throttled writes, errors, abort, reset.
module tb_bus_burst_memory_slave;

  logic        clock;
  logic        reset;
  logic        bi_begin;
  logic [31:0] bi_ad;
  logic        bi_rnw;
  logic [7:0]  bi_burst;
  logic        bi_valid;
  logic        bi_end;
  logic [31:0] bo_ad;
  logic        bo_valid;
  logic        bo_end;
  logic        bo_busy;
  logic        bo_err;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] rd_buf [64];
  logic [31:0] wr_buf [16];
  int          busy_log [$];

  bus_burst_memory_slave #(
    .BASE_ADDR      (32'h0000_0000),
    .MEM_WORDS_LOG2 (10),
    .READ_LATENCY   (2),
    .BUSY_PERIOD    (3)
  ) dut (
    .clock                   (clock),
    .reset                   (reset),
    .busIn_begin_transaction (bi_begin),
    .busIn_address_data      (bi_ad),
    .busIn_read_n_write      (bi_rnw),
    .busIn_burst_size        (bi_burst),
    .busIn_data_valid        (bi_valid),
    .busIn_end_transaction   (bi_end),
    .busOut_address_data     (bo_ad),
    .busOut_data_valid       (bo_valid),
    .busOut_end_transaction  (bo_end),
    .busOut_busy             (bo_busy),
    .busOut_error            (bo_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Outputs are sampled and inputs driven at the falling edge.
  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [7:0] burst,
                         output int lat, output int nbeats, output int end_cnt,
                         output int end_cyc, output int err_cnt, output int err_cyc,
                         output int dirty);
    lat = -1; nbeats = 0; end_cnt = 0; end_cyc = -1; err_cnt = 0; err_cyc = -1; dirty = 0;
    bi_begin = 1'b1; bi_ad = addr; bi_rnw = 1'b1; bi_burst = burst;
    step();
    bi_begin = 1'b0; bi_ad = '0;
    for (int c = 1; c <= 40; c++) begin
      if (bo_valid) begin
        if (lat < 0) lat = c;
        if (nbeats < 64) rd_buf[nbeats] = bo_ad;
        nbeats++;
      end else if (bo_ad != '0) begin
        dirty++;
      end
      if (bo_end) begin
        end_cnt++;
        if (end_cyc < 0) end_cyc = c;
      end
      if (bo_err) begin
        err_cnt++;
        if (err_cyc < 0) err_cyc = c;
      end
      step();
    end
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [7:0] burst, input int n,
                          input bit send_end, output int err_cnt);
    int acc;
    int guard;
    err_cnt = 0;
    acc = 0;
    busy_log.delete();
    bi_begin = 1'b1; bi_ad = addr; bi_rnw = 1'b0; bi_burst = burst;
    step();
    bi_begin = 1'b0;
    for (int i = 0; i < n; i++) begin
      bi_valid = 1'b1; bi_ad = wr_buf[i];
      guard = 0;
      while (bo_busy && guard < 8) begin
        busy_log.push_back(acc);
        step();
        if (bo_err) err_cnt++;
        guard++;
      end
      step();
      if (bo_err) err_cnt++;
      acc++;
    end
    bi_valid = 1'b0; bi_ad = '0;
    if (send_end) begin
      bi_end = 1'b1;
      step();
      if (bo_err) err_cnt++;
      bi_end = 1'b0;
    end
  endtask

  initial begin
    int lat, nb, ec, ecy, erc, ercy, dirty, werr, guard, vcnt;
    reset = 1'b0; bi_begin = 1'b0; bi_ad = '0; bi_rnw = 1'b0; bi_burst = '0;
    bi_valid = 1'b0; bi_end = 1'b0;
    repeat (3) step();
    check_eq("rst_valid", 32'(bo_valid), 0);
    check_eq("rst_data", bo_ad, 0);
    check_eq("rst_end", 32'(bo_end), 0);
    check_eq("rst_busy", 32'(bo_busy), 0);
    check_eq("rst_err", 32'(bo_err), 0);
    reset = 1'b1;
    step();

    // Preload mem[3..12] = 100..109.
    for (int i = 0; i < 10; i++) wr_buf[i] = 32'(100 + i);
    do_write(32'd12, 8'd9, 10, 1'b1, werr);
    check_eq("pre_err", 32'(werr), 0);

    // 1: read burst of 10 from word 3.
    do_read(32'd12, 8'd9, lat, nb, ec, ecy, erc, ercy, dirty);
    check_eq("t1_lat", 32'(lat), 3);
    check_eq("t1_beats", 32'(nb), 10);
    for (int k = 0; k < 10; k++) check_eq($sformatf("t1_d%0d", k), rd_buf[k], 32'(100 + k));
    check_eq("t1_end_cnt", 32'(ec), 1);
    check_eq("t1_end_cyc", 32'(ecy), 13);
    check_eq("t1_err", 32'(erc), 0);
    check_eq("t1_zero", 32'(dirty), 0);

    // 2: throttled write of 1..8 to words 3..10.
    for (int i = 0; i < 8; i++) wr_buf[i] = 32'(i + 1);
    do_write(32'd12, 8'd7, 8, 1'b1, werr);
    check_eq("t2_err", 32'(werr), 0);
    check_eq("t2_nbusy", 32'(busy_log.size()), 2);
    if (busy_log.size() == 2) begin
      check_eq("t2_busy0", 32'(busy_log[0]), 3);
      check_eq("t2_busy1", 32'(busy_log[1]), 6);
    end
    do_read(32'd12, 8'd9, lat, nb, ec, ecy, erc, ercy, dirty);
    check_eq("t2_beats", 32'(nb), 10);
    for (int k = 0; k < 8; k++) check_eq($sformatf("t2_d%0d", k), rd_buf[k], 32'(k + 1));
    check_eq("t2_d8", rd_buf[8], 32'd108);
    check_eq("t2_d9", rd_buf[9], 32'd109);

    // 3: out-of-range and unaligned reads.
    do_read(32'hFFC, 8'd1, lat, nb, ec, ecy, erc, ercy, dirty);
    check_eq("t3a_beats", 32'(nb), 0);
    check_eq("t3a_err_cnt", 32'(erc), 1);
    check_eq("t3a_err_cyc", 32'(ercy), 1);
    check_eq("t3a_end", 32'(ec), 0);
    do_read(32'h0E, 8'd1, lat, nb, ec, ecy, erc, ercy, dirty);
    check_eq("t3b_beats", 32'(nb), 0);
    check_eq("t3b_err_cnt", 32'(erc), 1);
    check_eq("t3b_err_cyc", 32'(ercy), 1);

    // 4: write overrun; word 68 holds a marker first.
    wr_buf[0] = 32'h55;
    do_write(32'h110, 8'd0, 1, 1'b1, werr);
    for (int i = 0; i < 5; i++) wr_buf[i] = 32'hA0 + 32'(i);
    do_write(32'h100, 8'd3, 5, 1'b0, werr);
    check_eq("t4_err_at_beat5", 32'(bo_err), 1);
    check_eq("t4_err_cnt", 32'(werr), 1);
    step();
    check_eq("t4_err_pulse", 32'(bo_err), 0);
    do_read(32'h100, 8'd4, lat, nb, ec, ecy, erc, ercy, dirty);
    check_eq("t4_beats", 32'(nb), 5);
    for (int k = 0; k < 4; k++) check_eq($sformatf("t4_d%0d", k), rd_buf[k], 32'hA0 + 32'(k));
    check_eq("t4_untouched", rd_buf[4], 32'h55);

    // 5: read of 21 beats aborted after 4.
    bi_begin = 1'b1; bi_ad = 32'd12; bi_rnw = 1'b1; bi_burst = 8'd20;
    step();
    bi_begin = 1'b0; bi_ad = '0;
    nb = 0; guard = 0;
    while (nb < 4 && guard < 20) begin
      if (bo_valid) begin
        rd_buf[nb] = bo_ad;
        nb++;
      end
      if (nb < 4) step();
      guard++;
    end
    check_eq("t5_beats", 32'(nb), 4);
    for (int k = 0; k < 4; k++) check_eq($sformatf("t5_d%0d", k), rd_buf[k], 32'(k + 1));
    bi_end = 1'b1;
    step();
    bi_end = 1'b0;
    check_eq("t5_valid_off", 32'(bo_valid), 0);
    check_eq("t5_no_end0", 32'(bo_end), 0);
    step();
    check_eq("t5_no_end1", 32'(bo_end), 0);
    do_read(32'h100, 8'd0, lat, nb, ec, ecy, erc, ercy, dirty);
    check_eq("t5_next_beats", 32'(nb), 1);
    check_eq("t5_next_d0", rd_buf[0], 32'hA0);
    check_eq("t5_next_end", 32'(ec), 1);

    // 6: ignored begin and reset mid write.
    wr_buf[0] = 32'h11; wr_buf[1] = 32'h22;
    do_write(32'h200, 8'd5, 2, 1'b0, werr);
    bi_begin = 1'b1; bi_ad = 32'h100; bi_rnw = 1'b1; bi_burst = 8'd0;
    step();
    bi_begin = 1'b0; bi_ad = '0;
    vcnt = 0;
    for (int c = 0; c < 4; c++) begin
      if (bo_valid || bo_end || bo_err) vcnt++;
      step();
    end
    check_eq("t6_begin_ignored", 32'(vcnt), 0);
    bi_valid = 1'b1; bi_ad = 32'h33; reset = 1'b0;
    step();
    check_eq("t6_rst_valid", 32'(bo_valid), 0);
    check_eq("t6_rst_busy", 32'(bo_busy), 0);
    check_eq("t6_rst_err", 32'(bo_err), 0);
    check_eq("t6_rst_data", bo_ad, 0);
    reset = 1'b1; bi_valid = 1'b0; bi_ad = '0;
    step();
    do_read(32'h200, 8'd1, lat, nb, ec, ecy, erc, ercy, dirty);
    check_eq("t6_beats", 32'(nb), 2);
    check_eq("t6_d0", rd_buf[0], 32'h11);
    check_eq("t6_d1", rd_buf[1], 32'h22);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
